mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl_if.sv | 24 ++
 rtl/mul_seq_ctrl.sv | 114 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
// Operand/product handshake bundle for mul_seq_ctrl.
// master = requester/consumer side, slave = multiplier side.
interface mul_seq_ctrl_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   rs1;
  logic [N-1:0]   rs2;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] rd;
  logic           busy;

  modport master (
    output in_valid, rs1, rs2, out_ready,
    input  in_ready, out_valid, rd, busy
  );

  modport slave (
    input  in_valid, rs1, rs2, out_ready,
    output in_ready, out_valid, rd, busy
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per clock.
// Optional MUL_EARLY_EXIT_EN: finish RUN as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | one shift-and-add step per edge
// DONE  | product on rd, held until out_ready
module mul_seq_ctrl #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  mul_seq_ctrl_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;

  logic [N-1:0]   mplier_shift;
  logic [CW-1:0]  cnt_inc;
  logic           run_last;

  assign mplier_shift = mplier_q >> 1;
  assign cnt_inc      = cnt_q + 1'b1;

  // Early exit is safe: once the shifted multiplier is zero no further adds can occur.
`ifdef MUL_EARLY_EXIT_EN
  assign run_last = (cnt_inc == CW'(N)) || (mplier_shift == '0);
`else
  assign run_last = (cnt_inc == CW'(N));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (run_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            acc_q    <= '0;
            mcand_q  <= {{N{1'b0}}, bus.rs1};
            mplier_q <= bus.rs2;
            cnt_q    <= '0;
          end
        end
        S_RUN: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_shift;
          cnt_q    <= cnt_inc;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rd = acc_q;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed, table-driven bench for mul_seq_ctrl (N=16), plus reset corner sequences.
module tb_mul_seq_ctrl;
  localparam int N = 16;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef logic [N-1:0] rs_t;

  typedef struct {
    rs_t            rs1;
    rs_t            rs2;
    logic [2*N-1:0] exp_rd;
    int             lat_base;
    int             lat_early;
    int             hold;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  vec_t vecs[9];

  mul_seq_ctrl_if #(.N(N)) bus ();

  mul_seq_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int exp_lat;
    exp_lat = EARLY ? v.lat_early : v.lat_base;
    bus.rs1       = v.rs1;
    bus.rs2       = v.rs2;
    bus.in_valid  = 1'b1;
    bus.out_ready = (v.hold == 0);
    check($sformatf("v%0d in_ready_pre", idx), 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check($sformatf("v%0d busy_run", idx), 64'(bus.busy), 64'd1);
    lat = 0;
    // Scramble operands and toggle in_valid while the product is in progress.
    while (!bus.out_valid && lat < 200) begin
      bus.rs1      = rs_t'($urandom);
      bus.rs2      = rs_t'($urandom);
      bus.in_valid = ~bus.in_valid;
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    check($sformatf("v%0d latency", idx), 64'(lat), 64'(exp_lat));
    check($sformatf("v%0d rd", idx), 64'(bus.rd), 64'(v.exp_rd));
    for (int h = 0; h < v.hold; h++) begin
      bus.in_valid = 1'b1;
      tick();
      check($sformatf("v%0d hold%0d out_valid", idx, h), 64'(bus.out_valid), 64'd1);
      check($sformatf("v%0d hold%0d rd", idx, h), 64'(bus.rd), 64'(v.exp_rd));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check($sformatf("v%0d in_ready_post", idx), 64'(bus.in_ready), 64'd1);
    check($sformatf("v%0d out_valid_post", idx), 64'(bus.out_valid), 64'd0);
    tick();
    check($sformatf("v%0d single_product", idx), 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    n_vec = 0;
    n_err = 0;

    //          rs1       rs2       rd              base early hold
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F,   16,  3,    0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001,   16,  16,   0};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000,   16,  1,    0};
    vecs[3] = '{16'h0000, 16'h1234, 32'h00000000,   16,  13,   0};
    vecs[4] = '{16'h00FF, 16'h0100, 32'h0000FF00,   16,  9,    5};
    vecs[5] = '{16'h000A, 16'h000B, 32'h0000006E,   16,  4,    0};
    vecs[6] = '{16'h8000, 16'h8000, 32'h40000000,   16,  16,   2};
    vecs[7] = '{16'h0001, 16'h0001, 32'h00000001,   16,  1,    0};
    vecs[8] = '{16'h1234, 16'h5678, 32'h06260060,   16,  15,   1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst rd", 64'(bus.rd), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset on the 7th RUN edge aborts 2*2; rst also wins over in_valid at that edge.
    bus.rs1       = 16'h0002;
    bus.rs2       = 16'h0002;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int e = 0; e < 6; e++) tick();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("abort in_ready", 64'(bus.in_ready), 64'd1);
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort rd", 64'(bus.rd), 64'd0);
    lat = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (bus.out_valid) lat++;
    end
    check("abort no_product", 64'(lat), 64'd0);
    run_vec('{16'h0004, 16'h0004, 32'h00000010, 16, 3, 0}, 100);

    // Reset while DONE with the product pending.
    bus.rs1       = 16'h0007;
    bus.rs2       = 16'h0003;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("done_rst rd_before", 64'(bus.rd), 64'h15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("done_rst out_valid", 64'(bus.out_valid), 64'd0);
    check("done_rst in_ready", 64'(bus.in_ready), 64'd1);
    check("done_rst rd", 64'(bus.rd), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    check("done_rst idle_stays", 64'(bus.in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
